ir_packet_sequencer: RTL and testbench
======================================

Name: ir_packet_sequencer

Overview:
- Sequences one IR remote-control packet for the car from the 4-bit command held in the memory-mapped IR command register (address 0x90).
- Each packet: start burst, gap, car-select burst, gap, then four direction bits. Each bit is sent as a long (asserted) or short (deasserted) burst followed by a gap.
- Bursts are modulated onto a carrier derived from CLK. The block drives the IR LED pin directly.
- It is triggered by a periodic send strobe, nominally 10 Hz, from the timer.

Parameters:
- CARRIER_HALF, 1250, CLK cycles per carrier half-period (100 MHz / 2500 = 40 kHz); 16-bit counter.
- START_LEN, 191, start burst length in carrier periods.
- CARSEL_LEN, 47, car-select burst length in carrier periods.
- GAP_LEN, 25, gap length in carrier periods.
- ASSERT_LEN, 47, burst length in carrier periods for a command bit = 1.
- DEASSERT_LEN, 22, burst length in carrier periods for a command bit = 0.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  synchronous, active-high reset.
- SEND_PACKET  in  1  single-cycle strobe requesting one packet.
- COMMAND  in  4  [3]=right, [2]=left, [1]=backward, [0]=forward; low nibble of the IR command register.
- IR_LED  out  1  modulated IR output.
- BUSY  out  1  high while a packet is in progress.
- DONE  out  1  one-cycle pulse on packet completion.

Behaviour:
- Reset: clocked on RESET, active-high, synchronous; clock is CLK. On reset, IR_LED=0, BUSY=0, DONE=0, state=IDLE, all counters=0, latched command=0.
- States: IDLE, START, GAP, CARSEL, BIT; bit index 0..3 selects COMMAND[3-idx], so right is sent first and forward last.
  - IDLE: SEND_PACKET=1 at edge t latches COMMAND and moves to START.
  - START → GAP → CARSEL → GAP → BIT(idx0) → GAP → BIT(idx1) → … → BIT(idx3) → GAP → IDLE.
  - A GAP returns to the next burst state, tracked by a phase register. The final GAP returns to IDLE.
- Carrier:
  - Cycle counter runs 0..2*CARRIER_HALF-1 and wraps.
  - Carrier is high for counts 0..CARRIER_HALF-1.
  - The counter is cleared when a packet starts, so the first burst begins with a full high half-period.
- Lengths:
  - Each state lasts (length × 2*CARRIER_HALF) CLK cycles; the period counter advances at each carrier wrap.
  - State change and period counter clear occur on the wrap that completes the last period.
  - Burst length in BIT state is ASSERT_LEN when the latched bit is 1, otherwise DEASSERT_LEN.
- Outputs:
  - IR_LED is registered: it equals the carrier during START, CARSEL and BIT, and is 0 in GAP and IDLE.
  - BUSY is registered and high in every non-IDLE state: from cycle t+1 through the last GAP cycle.
  - DONE pulses on the cycle BUSY falls, i.e. the first IDLE cycle.
- Packet length: (START_LEN + CARSEL_LEN + Σbits + 6*GAP_LEN) × 2*CARRIER_HALF cycles.
- SEND_PACKET while BUSY: ignored, not queued. A SEND_PACKET coincident with the DONE cycle is accepted; that cycle is IDLE.
- COMMAND changes mid-packet: no effect; only the value latched at acceptance is sent.
- RESET mid-packet: IR_LED=0 and BUSY=0 on the next cycle, with no DONE pulse.
- Lengths of 0 are illegal, unchecked.

Test Plan:
Bench parameters: CARRIER_HALF=2, START_LEN=4, CARSEL_LEN=3, GAP_LEN=2, ASSERT_LEN=2, DEASSERT_LEN=1.
1. Reset, then idle 50 cycles → IR_LED=0, BUSY=0, DONE=0 throughout.
2. COMMAND=4'b0101, one SEND_PACKET pulse at cycle t → BUSY high for exactly 100 cycles from t+1; IR_LED shows 13 rising edges (4+3+1+2+1+2); IR_LED high at t+1..t+2 and low at t+3..t+4; DONE pulses once at t+101.
3. COMMAND=4'b1111 → packet 27 carrier periods (108 cycles); COMMAND=4'b0000 → 23 periods (92 cycles); burst widths per bit are 8 vs 4 cycles.
4. SEND_PACKET re-pulsed at t+10 and t+50 during the scenario-2 packet, with COMMAND changed to 4'b1010 at t+20 → waveform identical to scenario 2, single DONE.
5. SEND_PACKET on the DONE cycle → new packet begins the next cycle with no idle gap; BUSY low only for the DONE cycle.
6. RESET asserted at t+40 mid-packet → IR_LED=0 and BUSY=0 at t+41; no DONE; a fresh SEND_PACKET then yields a full 100-cycle packet.

Source files
------------

// File: rtl/ir_packet_sequencer.sv
// Sequences one IR remote-control packet (start, car-select, four direction bits)
// and modulates the bursts onto a CLK-derived carrier that drives the IR LED pin.
module ir_packet_sequencer #(
    parameter int CARRIER_HALF = 1250,
    parameter int START_LEN    = 191,
    parameter int CARSEL_LEN   = 47,
    parameter int GAP_LEN      = 25,
    parameter int ASSERT_LEN   = 47,
    parameter int DEASSERT_LEN = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND_PACKET,
    input  logic [3:0] COMMAND,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_CARSEL = 3'd3;
    localparam logic [2:0] S_BIT    = 3'd4;

    localparam logic [15:0] CYC_LAST = 16'(2 * CARRIER_HALF - 1);
    localparam logic [15:0] HALF     = 16'(CARRIER_HALF);

    // phase_q counts bursts already sent; a GAP uses it to pick what follows.
    localparam logic [2:0] PH_AFTER_START = 3'd1;
    localparam logic [2:0] PH_AFTER_LAST  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] per_q, per_d;
    logic [2:0]  phase_q, phase_d;
    logic [1:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        ir_q, ir_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        cur_bit;
    logic [15:0] cur_len;
    logic        wrap;
    logic        state_end;
    logic        burst_d;

    // Bit index 0 carries COMMAND[3] (right), index 3 carries COMMAND[0] (forward).
    assign cur_bit = cmd_q[2'd3 - bit_idx_q];

    always_comb begin
        cur_len = 16'd1;
        case (state_q)
            S_START:  cur_len = 16'(START_LEN);
            S_CARSEL: cur_len = 16'(CARSEL_LEN);
            S_GAP:    cur_len = 16'(GAP_LEN);
            S_BIT:    cur_len = cur_bit ? 16'(ASSERT_LEN) : 16'(DEASSERT_LEN);
            default:  cur_len = 16'd1;
        endcase
    end

    assign wrap      = (cyc_q == CYC_LAST);
    assign state_end = wrap && (per_q == cur_len - 16'd1);

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        per_d     = per_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;

        if (state_q == S_IDLE) begin
            cyc_d = 16'd0;
            per_d = 16'd0;
            if (SEND_PACKET) begin
                cmd_d     = COMMAND;
                phase_d   = 3'd0;
                bit_idx_d = 2'd0;
                state_d   = S_START;
            end
        end else begin
            cyc_d = wrap ? 16'd0 : cyc_q + 16'd1;
            if (wrap) begin
                per_d = per_q + 16'd1;
            end
            if (state_end) begin
                per_d = 16'd0;
                case (state_q)
                    S_START: begin
                        state_d = S_GAP;
                        phase_d = PH_AFTER_START;
                    end
                    S_CARSEL: begin
                        state_d = S_GAP;
                        phase_d = 3'd2;
                    end
                    S_BIT: begin
                        state_d = S_GAP;
                        phase_d = {1'b0, bit_idx_q} + 3'd3;
                    end
                    S_GAP: begin
                        if (phase_q == PH_AFTER_START) begin
                            state_d = S_CARSEL;
                        end else if (phase_q == PH_AFTER_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = S_BIT;
                            bit_idx_d = 2'(phase_q - 3'd2);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from next-state values so they line up with state_q.
    assign burst_d = (state_d == S_START) || (state_d == S_CARSEL) || (state_d == S_BIT);
    assign ir_d    = burst_d && (cyc_d < HALF);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cyc_q     <= 16'd0;
            per_q     <= 16'd0;
            phase_q   <= 3'd0;
            bit_idx_q <= 2'd0;
            cmd_q     <= 4'd0;
            ir_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            per_q     <= per_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            cmd_q     <= cmd_d;
            ir_q      <= ir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign IR_LED = ir_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_ir_packet_sequencer.sv
// Self-checking bench for ir_packet_sequencer with shortened carrier and burst lengths;
// expected waveforms come from a segment-list model of the packet format.
module tb_ir_packet_sequencer;

    localparam int CH = 2;
    localparam int SL = 4;
    localparam int CL = 3;
    localparam int GL = 2;
    localparam int AL = 2;
    localparam int DL = 1;

    localparam int M_NORMAL  = 0;
    localparam int M_REPULSE = 1;
    localparam int M_CHAIN   = 2;
    localparam int M_NOISE   = 3;
    localparam int M_ABORT   = 4;

    logic       clk;
    logic       rst;
    logic       send;
    logic [3:0] cmd;
    logic       ir;
    logic       busy;
    logic       done;

    ir_packet_sequencer #(
        .CARRIER_HALF(CH),
        .START_LEN   (SL),
        .CARSEL_LEN  (CL),
        .GAP_LEN     (GL),
        .ASSERT_LEN  (AL),
        .DEASSERT_LEN(DL)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .SEND_PACKET(send),
        .COMMAND    (cmd),
        .IR_LED     (ir),
        .BUSY       (busy),
        .DONE       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit exp_q[$];

    typedef struct {
        logic [3:0] cmd;
        int         mode;
        logic [3:0] next_cmd;
        int         exp_len;
        int         exp_rises;
    } vec_t;

    // Append one segment of whole carrier periods, either modulated or dark.
    task automatic add_seg(input bit on, input int len);
        for (int p = 0; p < len; p++)
            for (int c = 0; c < 2 * CH; c++)
                exp_q.push_back(on && (c < CH));
    endtask

    task automatic build(input logic [3:0] c);
        exp_q.delete();
        add_seg(1'b1, SL);
        add_seg(1'b0, GL);
        add_seg(1'b1, CL);
        add_seg(1'b0, GL);
        for (int i = 0; i < 4; i++) begin
            add_seg(1'b1, c[3 - i] ? AL : DL);
            add_seg(1'b0, GL);
        end
    endtask

    task automatic chk(input string name, input int k, input logic e_ir, input logic e_busy,
                       input logic e_done);
        vectors++;
        if (ir !== e_ir || busy !== e_busy || done !== e_done) begin
            errors++;
            $display("FAIL %s cycle %0d: ir/busy/done got %b%b%b expected %b%b%b",
                     name, k, ir, busy, done, e_ir, e_busy, e_done);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic send_pkt(input logic [3:0] c);
        @(negedge clk);
        send = 1'b1;
        cmd  = c;
    endtask

    // Assumes SEND_PACKET was sampled at the edge just before the first negedge here.
    task automatic check_packet(input logic [3:0] c, input int mode, input logic [3:0] nxt,
                                output int busy_cnt, output int rises);
        int   n;
        logic prev;
        build(c);
        n        = exp_q.size();
        busy_cnt = 0;
        rises    = 0;
        prev     = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            send = 1'b0;
            if (mode == M_ABORT && k == 41) begin
                chk("reset_abort", k, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                for (int j = 0; j < 110; j++) begin
                    @(negedge clk);
                    chk("post_reset_idle", k + 1 + j, 1'b0, 1'b0, 1'b0);
                end
                return;
            end
            if (k <= n) chk("packet", k, exp_q[k - 1], 1'b1, 1'b0);
            else        chk("done", k, 1'b0, 1'b0, 1'b1);
            if (busy === 1'b1) busy_cnt++;
            if (ir === 1'b1 && prev !== 1'b1) rises++;
            prev = ir;
            case (mode)
                M_REPULSE: begin
                    if (k == 10 || k == 50) send = 1'b1;
                    if (k == 20) cmd = 4'b1010;
                end
                M_NOISE: cmd = 4'($urandom);
                M_ABORT: if (k == 40) rst = 1'b1;
                M_CHAIN: if (k == n + 1) begin
                    send = 1'b1;
                    cmd  = nxt;
                end
                default: ;
            endcase
        end
    endtask

    vec_t vecs[8];

    initial begin
        int bc;
        int rc;
        rst  = 1'b1;
        send = 1'b0;
        cmd  = 4'd0;

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        chk("reset_state", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle", i, 1'b0, 1'b0, 1'b0);
        end

        // Packet lengths: 4+3+sum(bits)+6*2 periods of 4 cycles; rises: 4+3+sum(bits).
        vecs[0] = '{4'b0101, M_NORMAL,  4'b0000, 100, 13};
        vecs[1] = '{4'b1111, M_NORMAL,  4'b0000, 108, 15};
        vecs[2] = '{4'b0000, M_NORMAL,  4'b0000,  92, 11};
        vecs[3] = '{4'b0101, M_REPULSE, 4'b0000, 100, 13};
        vecs[4] = '{4'b1000, M_NORMAL,  4'b0000,  96, 12};
        vecs[5] = '{4'b0011, M_CHAIN,   4'b1100, 100, 13};
        vecs[6] = '{4'b1100, M_NORMAL,  4'b0000, 100, 13};
        vecs[7] = '{4'b1010, M_NOISE,   4'b0000, 100, 13};

        for (int v = 0; v < 8; v++) begin
            // Row 6 is the back-to-back packet already launched by row 5.
            if (v != 6) send_pkt(vecs[v].cmd);
            check_packet(vecs[v].cmd, vecs[v].mode, vecs[v].next_cmd, bc, rc);
            chk_int("busy_length", bc, vecs[v].exp_len);
            chk_int("rising_edges", rc, vecs[v].exp_rises);
            $display("packet cmd=%b mode=%0d busy=%0d rises=%0d", vecs[v].cmd, vecs[v].mode, bc, rc);
        end

        // Reset mid-packet, then a fresh full packet.
        send_pkt(4'b0101);
        check_packet(4'b0101, M_ABORT, 4'b0000, bc, rc);
        $display("packet cmd=0101 aborted by reset at cycle 40");
        send_pkt(4'b0101);
        check_packet(4'b0101, M_NORMAL, 4'b0000, bc, rc);
        chk_int("busy_length_after_reset", bc, 100);
        $display("packet cmd=0101 after reset busy=%0d rises=%0d", bc, rc);

        // Randomized commands against the model.
        for (int r = 0; r < 10; r++) begin
            logic [3:0] rc_cmd;
            int         mode;
            int         gap;
            rc_cmd = 4'($urandom);
            mode   = ($urandom_range(0, 1) == 1) ? M_NOISE : M_NORMAL;
            gap    = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("random_idle", g, 1'b0, 1'b0, 1'b0);
            end
            send_pkt(rc_cmd);
            check_packet(rc_cmd, mode, 4'b0000, bc, rc);
            chk_int("random_busy_length",
                    bc, 4 * (SL + CL + 6 * GL + (rc_cmd[3] ? AL : DL) + (rc_cmd[2] ? AL : DL)
                             + (rc_cmd[1] ? AL : DL) + (rc_cmd[0] ? AL : DL)));
            $display("packet cmd=%b mode=%0d busy=%0d rises=%0d (random)", rc_cmd, mode, bc, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
